// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network output path (AER encoder and its event FIFO).
// AER_TIMESTAMP_EN adds a timestep field to every buffered event.
package snn_pkg;

    localparam int N_NEURONS  = 8;
    localparam int TS_W       = 8;
    localparam int DROP_CNT_W = 8;

    // Address width for a vector of n neurons; a single neuron still needs one address bit.
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW = aw_of(N_NEURONS);

    typedef enum logic {
        IDLE,
        SCAN
    } aer_state_e;

    typedef struct packed {
        logic [AW-1:0]   addr;
`ifdef AER_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } aer_event_t;

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous show-ahead FIFO of AER events; DEPTH must be a power of two so the pointers wrap freely.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module aer_event_fifo
    import snn_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  aer_event_t    din,
    output aer_event_t    dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    aer_event_t    mem [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [LW-1:0] count_q;
    logic          pushOk;
    logic          popOk;

    assign full   = (count_q == LW'(DEPTH));
    assign empty  = (count_q == '0);
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;
    assign dout   = mem[rdPtr_q];
    assign level  = count_q;

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({pushOk, popOk})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures per-timestep spike vectors and serialises set bits, lowest index first, into AER events.
// N_NEURONS and TS_W come from snn_pkg; define AER_TIMESTAMP_EN to carry the capture timestep on event_ts.
module spike_aer_encoder
    import snn_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_NEURONS-1:0]  spike_in,
    input  logic                  spike_valid,
    input  logic                  event_ready,
    output logic                  event_valid,
    output logic [AW-1:0]         event_addr,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_W-1:0]       event_ts,
`endif
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    aer_state_e            state_q;
    logic [N_NEURONS-1:0]  pending_q;
    logic [N_NEURONS-1:0]  pendingClr;
    logic [AW-1:0]         lowIdx;
    logic                  lastBit;
    logic                  newVec;
    logic                  pushEn;
    logic                  dropEn;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] dropCnt_q;
    logic [DROP_CNT_W-1:0] dropCnt_d;
    aer_event_t            fifoDin;
    aer_event_t            fifoDout;
    logic                  fifoFull;
    logic                  fifoEmpty;

    // Scanning high to low leaves the lowest set index as the final assignment.
    always_comb begin
        lowIdx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowIdx = AW'(i);
            end
        end
    end

    assign pendingClr = pending_q & (pending_q - N_NEURONS'(1));
    assign lastBit    = (pendingClr == '0);
    assign newVec     = spike_valid && (spike_in != '0);
    assign pushEn     = (state_q == SCAN) && !fifoFull;
    assign dropEn     = newVec && (state_q == SCAN) && !(pushEn && lastBit);
    assign dropCnt_d  = (dropCnt_q == '1) ? dropCnt_q : dropCnt_q + DROP_CNT_W'(1);

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] tsCnt_q;
    logic [TS_W-1:0] pendTs_q;

    // Every strobe advances the timestep, whether the vector is empty, accepted or dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tsCnt_q <= '0;
        end else if (spike_valid) begin
            tsCnt_q <= tsCnt_q + TS_W'(1);
        end
    end
`endif

    always_comb begin
        fifoDin      = '0;
        fifoDin.addr = lowIdx;
`ifdef AER_TIMESTAMP_EN
        fifoDin.ts   = pendTs_q;
`endif
    end

    // Pushing the last pending bit frees the scanner, so a vector arriving that cycle is taken directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
`ifdef AER_TIMESTAMP_EN
            pendTs_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (newVec) begin
                        pending_q <= spike_in;
                        state_q   <= SCAN;
`ifdef AER_TIMESTAMP_EN
                        pendTs_q  <= tsCnt_q;
`endif
                    end
                end
                SCAN: begin
                    if (pushEn) begin
                        if (!lastBit) begin
                            pending_q <= pendingClr;
                        end else if (newVec) begin
                            pending_q <= spike_in;
`ifdef AER_TIMESTAMP_EN
                            pendTs_q  <= tsCnt_q;
`endif
                        end else begin
                            pending_q <= '0;
                            state_q   <= IDLE;
                        end
                    end
                end
            endcase
            if (dropEn) begin
                overflow_q <= 1'b1;
                dropCnt_q  <= dropCnt_d;
            end
        end
    end

    aer_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pushEn),
        .pop   (event_ready),
        .din   (fifoDin),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (fifo_level)
    );

    // Stale storage is masked so the stream shows zero whenever nothing is buffered.
    assign event_valid = !fifoEmpty;
    assign event_addr  = fifoEmpty ? '0 : fifoDout.addr;
`ifdef AER_TIMESTAMP_EN
    assign event_ts    = fifoEmpty ? '0 : fifoDout.ts;
`endif
    assign overflow    = overflow_q;
    assign drop_cnt    = dropCnt_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: expected events are queued as vectors are driven and
// checked in order as the stream hands them out; AER_TIMESTAMP_EN also checks event timesteps.
module tb_spike_aer_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] spike_in;
    logic       spike_valid;
    logic       event_ready;
    logic       event_valid;
    logic [2:0] event_addr;
`ifdef AER_TIMESTAMP_EN
    logic [7:0] event_ts;
`endif
    logic [3:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_cnt;

    int assertCnt = 0;
    int failCnt   = 0;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] ts;
    } expEvt_t;

    expEvt_t    expQ[$];
    logic [7:0] tsModel;
    logic [2:0] seqAddr [3];

    always #5 clk = ~clk;

    spike_aer_encoder #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_in    (spike_in),
        .spike_valid (spike_valid),
        .event_ready (event_ready),
        .event_valid (event_valid),
        .event_addr  (event_addr),
`ifdef AER_TIMESTAMP_EN
        .event_ts    (event_ts),
`endif
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Queues one expected event per set bit, lowest index first, tagged with the capture timestep.
    task automatic pushExpected(input logic [7:0] vec);
        expEvt_t e;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                e.addr = 3'(i);
                e.ts   = tsModel;
                expQ.push_back(e);
            end
        end
    endtask

    // Drives one clock cycle of input and returns just after the sampling edge.
    task automatic applyStimulus(input logic [7:0] vec, input logic valid, input logic accept);
        spike_in    = vec;
        spike_valid = valid;
        if (valid && accept) begin
            pushExpected(vec);
        end
        if (valid) begin
            tsModel = tsModel + 8'd1;
        end
        @(posedge clk);
        #1;
        spike_in    = '0;
        spike_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || event_valid) && n < budget) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
            n++;
        end
        assertCnt++;
        assert (n < budget) else begin
            failCnt++;
            $error("[TB] FAIL drainTimeout: observed %0d cycles with %0d events pending, required fewer than %0d", n, expQ.size(), budget);
        end
    endtask

    // Scoreboard: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        expEvt_t e;
        if (rst_n && event_valid && event_ready) begin
            assertCnt++;
            assert (expQ.size() > 0) else begin
                failCnt++;
                $error("[TB] FAIL unexpectedEvent: observed addr=%0d, expected no event", event_addr);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("eventAddr", 32'(event_addr), 32'(e.addr));
`ifdef AER_TIMESTAMP_EN
                checkOutput("eventTs", 32'(event_ts), 32'(e.ts));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        spike_in    = '0;
        spike_valid = 1'b0;
        event_ready = 1'b0;
        tsModel     = '0;
        seqAddr     = '{3'd2, 3'd5, 3'd7};
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetValid", 32'(event_valid), 32'd0);
        checkOutput("resetLevel", 32'(fifo_level), 32'd0);
        checkOutput("resetAddr", 32'(event_addr), 32'd0);
        checkOutput("resetOverflow", 32'(overflow), 32'd0);
        checkOutput("resetDropCnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;

        // Basic serialisation and two-cycle latency.
        event_ready = 1'b1;
        applyStimulus(8'hA5, 1'b1, 1'b1);
        checkOutput("latencyT1Valid", 32'(event_valid), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("latencyT2Valid", 32'(event_valid), 32'd1);
        checkOutput("latencyT2Addr", 32'(event_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
            checkOutput("seqAddr", 32'(event_addr), 32'(seqAddr[i]));
        end
        waitDrain(20);

        // Empty vector produces nothing and is not a drop.
        applyStimulus(8'h00, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("zeroVecValid", 32'(event_valid), 32'd0);
        checkOutput("zeroVecDropCnt", 32'(drop_cnt), 32'd0);

        // Back-to-back accept on the last-bit cycle.
        applyStimulus(8'h80, 1'b1, 1'b1);
        applyStimulus(8'h03, 1'b1, 1'b1);
        waitDrain(20);
        checkOutput("b2bDropCnt", 32'(drop_cnt), 32'd0);
        checkOutput("b2bOverflow", 32'(overflow), 32'd0);

        // Fill under backpressure, drop a vector, then drain.
        event_ready = 1'b0;
        applyStimulus(8'hFF, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0);
        checkOutput("dropOverflow", 32'(overflow), 32'd1);
        checkOutput("dropCnt1", 32'(drop_cnt), 32'd1);
        idleCycles(8);
        checkOutput("fullLevel", 32'(fifo_level), 32'd8);
        checkOutput("fullValid", 32'(event_valid), 32'd1);
        checkOutput("stallAddr0", 32'(event_addr), 32'd0);
        idleCycles(3);
        checkOutput("stallAddr1", 32'(event_addr), 32'd0);
        event_ready = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("firstPopLevel", 32'(fifo_level), 32'd7);
        checkOutput("firstPopAddr", 32'(event_addr), 32'd1);
        waitDrain(30);

        // Full FIFO blocks a push even with a simultaneous pop.
        event_ready = 1'b0;
        applyStimulus(8'hFF, 1'b1, 1'b1);
        idleCycles(9);
        checkOutput("refillLevel", 32'(fifo_level), 32'd8);
        applyStimulus(8'h01, 1'b1, 1'b1);
        idleCycles(2);
        event_ready = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        event_ready = 1'b0;
        checkOutput("popBlocksPushLevel", 32'(fifo_level), 32'd7);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("stalledPushLevel", 32'(fifo_level), 32'd8);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'h02, 1'b1, (i == 0));
            if (i == 10) begin
                checkOutput("dropCnt11", 32'(drop_cnt), 32'd11);
            end
        end
        checkOutput("dropCntSat", 32'(drop_cnt), 32'd255);
        checkOutput("satOverflow", 32'(overflow), 32'd1);

        // Reset while the scanner is stuck mid-vector.
        rst_n = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0);
        expQ.delete();
        tsModel = '0;
        checkOutput("midResetValid", 32'(event_valid), 32'd0);
        checkOutput("midResetLevel", 32'(fifo_level), 32'd0);
        checkOutput("midResetAddr", 32'(event_addr), 32'd0);
        checkOutput("midResetOverflow", 32'(overflow), 32'd0);
        checkOutput("midResetDropCnt", 32'(drop_cnt), 32'd0);
        rst_n       = 1'b1;
        event_ready = 1'b1;
        idleCycles(3);
        checkOutput("postResetNoEvent", 32'(event_valid), 32'd0);
        applyStimulus(8'h42, 1'b1, 1'b1);
        waitDrain(20);
        checkOutput("postResetLevel", 32'(fifo_level), 32'd0);

        // Timestep wrap: 257th strobe captures timestep 0.
        rst_n = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0);
        expQ.delete();
        tsModel = '0;
        rst_n   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b0);
        end
        applyStimulus(8'h10, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("wrapValid", 32'(event_valid), 32'd1);
        checkOutput("wrapAddr", 32'(event_addr), 32'd4);
`ifdef AER_TIMESTAMP_EN
        checkOutput("wrapTs", 32'(event_ts), 32'd0);
`endif
        waitDrain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
